rvvi_retire_buffer: RTL

- Sits directly downstream of the RVVI retirement signal bundle for a single hart.
- Accepts up to NRET retirement lanes per cycle and compacts the valid lanes in lane order.
- Buffers them in a FIFO and presents one retirement per cycle over a valid/ready handshake to the trace/compare consumer.
- Checks order-count continuity and tracks halt so the consumer sees a clean, gap-checked, in-order stream.

---
 rtl/rvvi_retire_buffer_if.sv | 66 ++++++
 rtl/rvvi_retire_buffer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rvvi_retire_buffer_if.sv
// Retirement bundle interface for rvvi_retire_buffer.
//   in_*      : NRET-lane RVVI retirement inputs, lane k at [k*W +: W]
//   in_ready  : buffer can take a full NRET-lane beat
//   out_*     : single-lane head entry with valid/ready handshake
//   count, halted, err_* : buffer status and sticky error captures
// master drives the retirement lanes and consumes the output stream;
// slave is the buffer itself.
interface rvvi_retire_buffer_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8
);
    logic [NRET-1:0]        in_valid;
    logic [NRET*XLEN-1:0]   in_order;
    logic [NRET*ILEN-1:0]   in_insn;
    logic [NRET-1:0]        in_trap;
    logic [NRET-1:0]        in_halt;
    logic [NRET*2-1:0]      in_mode;
    logic [NRET*XLEN-1:0]   in_pc_rdata;
    logic [NRET*XLEN-1:0]   in_pc_wdata;
    logic [NRET*5-1:0]      in_x_addr;
    logic [NRET*XLEN-1:0]   in_x_wdata;
    logic [NRET-1:0]        in_x_wb;
    logic                   in_ready;

    logic                   out_valid;
    logic                   out_ready;
    logic [XLEN-1:0]        out_order;
    logic [ILEN-1:0]        out_insn;
    logic                   out_trap;
    logic                   out_halt;
    logic [1:0]             out_mode;
    logic [XLEN-1:0]        out_pc_rdata;
    logic [XLEN-1:0]        out_pc_wdata;
    logic [4:0]             out_x_addr;
    logic [XLEN-1:0]        out_x_wdata;
    logic                   out_x_wb;

    logic [$clog2(DEPTH):0] count;
    logic                   halted;
    logic                   err_order;
    logic [XLEN-1:0]        err_exp;
    logic [XLEN-1:0]        err_got;
    logic                   err_post_halt;

    modport master (
        output in_valid, in_order, in_insn, in_trap, in_halt, in_mode,
               in_pc_rdata, in_pc_wdata, in_x_addr, in_x_wdata, in_x_wb,
               out_ready,
        input  in_ready, out_valid, out_order, out_insn, out_trap, out_halt,
               out_mode, out_pc_rdata, out_pc_wdata, out_x_addr, out_x_wdata,
               out_x_wb, count, halted, err_order, err_exp, err_got,
               err_post_halt
    );

    modport slave (
        input  in_valid, in_order, in_insn, in_trap, in_halt, in_mode,
               in_pc_rdata, in_pc_wdata, in_x_addr, in_x_wdata, in_x_wb,
               out_ready,
        output in_ready, out_valid, out_order, out_insn, out_trap, out_halt,
               out_mode, out_pc_rdata, out_pc_wdata, out_x_addr, out_x_wdata,
               out_x_wb, count, halted, err_order, err_exp, err_got,
               err_post_halt
    );
endinterface

// File: rtl/rvvi_retire_buffer.sv
// rvvi_retire_buffer: compacts up to NRET RVVI retirement lanes per cycle
// into a FIFO and presents them one per cycle (first-word-fall-through)
// to a trace/compare consumer. Checks order-count continuity and tracks
// halt: once a halt retires the buffer stops accepting, drains, and
// reports halted.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (flushes FIFO, clears errors)
//   bus   : rvvi_retire_buffer_if slave (lanes in, head out, status)
module rvvi_retire_buffer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = 8
) (
    input logic                 clk,
    input logic                 reset,
    rvvi_retire_buffer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic [XLEN-1:0] order;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic            halt;
        logic [1:0]      mode;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      x_addr;
        logic [XLEN-1:0] x_wdata;
        logic            x_wb;
    } entry_t;

    state_t          state, state_next;
    entry_t          mem [DEPTH];
    entry_t          lane_e [NRET];
    entry_t          head;
    logic [PW-1:0]   slot_off [NRET];
    logic [PW-1:0]   off;
    logic [NRET-1:0] keep;
    logic            seen_halt, halt_kept, post_halt_drop;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next, npush;
    logic            in_ready, out_valid, push, pop;

    logic            exp_valid_q, exp_valid_next;
    logic [XLEN-1:0] exp_q, exp_next;
    logic            err_order_q, err_order_next;
    logic [XLEN-1:0] err_exp_q, err_exp_next, err_got_q, err_got_next;
    logic            err_post_halt_q;

    // Lane unpack, halt truncation and compaction offsets.
    always_comb begin
        keep           = '0;
        off            = '0;
        npush          = '0;
        seen_halt      = 1'b0;
        halt_kept      = 1'b0;
        post_halt_drop = 1'b0;
        for (int unsigned k = 0; k < NRET; k++) begin
            lane_e[k].order    = bus.in_order[k*XLEN +: XLEN];
            lane_e[k].insn     = bus.in_insn[k*ILEN +: ILEN];
            lane_e[k].trap     = bus.in_trap[k];
            lane_e[k].halt     = bus.in_halt[k];
            lane_e[k].mode     = bus.in_mode[k*2 +: 2];
            lane_e[k].pc_rdata = bus.in_pc_rdata[k*XLEN +: XLEN];
            lane_e[k].pc_wdata = bus.in_pc_wdata[k*XLEN +: XLEN];
            lane_e[k].x_addr   = bus.in_x_addr[k*5 +: 5];
            lane_e[k].x_wdata  = bus.in_x_wdata[k*XLEN +: XLEN];
            lane_e[k].x_wb     = bus.in_x_wb[k];
            slot_off[k]        = off;
            if (bus.in_valid[k] && seen_halt) begin
                post_halt_drop = 1'b1;
            end
            keep[k] = bus.in_valid[k] && !seen_halt;
            if (keep[k]) begin
                off   = off + 1'b1;
                npush = npush + 1'b1;
                if (bus.in_halt[k]) begin
                    seen_halt = 1'b1;
                    halt_kept = 1'b1;
                end
            end
        end
    end

    assign in_ready   = (state == RUN) && (count <= CW'(DEPTH - NRET));
    assign push       = in_ready && (|bus.in_valid);
    assign out_valid  = (count != '0);
    assign pop        = out_valid && bus.out_ready;
    assign count_next = count + (push ? npush : '0) - CW'(pop);

    // Order check walks kept lanes in compaction order. Every kept lane
    // resyncs exp to order+1 whether it matched or not, so the three
    // cases collapse to one update plus a first-mismatch capture.
    always_comb begin
        exp_next       = exp_q;
        exp_valid_next = exp_valid_q;
        err_order_next = err_order_q;
        err_exp_next   = err_exp_q;
        err_got_next   = err_got_q;
        if (push) begin
            for (int unsigned k = 0; k < NRET; k++) begin
                if (keep[k]) begin
                    if (exp_valid_next && (lane_e[k].order != exp_next)
                        && !err_order_next) begin
                        err_order_next = 1'b1;
                        err_exp_next   = exp_next;
                        err_got_next   = lane_e[k].order;
                    end
                    exp_next       = lane_e[k].order + 1'b1;
                    exp_valid_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (push && halt_kept) state_next = DRAIN;
            DRAIN:   if (count_next == '0)  state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            exp_q           <= '0;
            exp_valid_q     <= 1'b0;
            err_order_q     <= 1'b0;
            err_exp_q       <= '0;
            err_got_q       <= '0;
            err_post_halt_q <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            exp_q       <= exp_next;
            exp_valid_q <= exp_valid_next;
            err_order_q <= err_order_next;
            err_exp_q   <= err_exp_next;
            err_got_q   <= err_got_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(npush);
                if (post_halt_drop) begin
                    err_post_halt_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            for (int unsigned k = 0; k < NRET; k++) begin
                if (keep[k]) begin
                    mem[wr_ptr + slot_off[k]] <= lane_e[k];
                end
            end
        end
    end

    // Gating with out_valid keeps out_* at zero after reset and when empty.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_order     = head.order;
    assign bus.out_insn      = head.insn;
    assign bus.out_trap      = head.trap;
    assign bus.out_halt      = head.halt;
    assign bus.out_mode      = head.mode;
    assign bus.out_pc_rdata  = head.pc_rdata;
    assign bus.out_pc_wdata  = head.pc_wdata;
    assign bus.out_x_addr    = head.x_addr;
    assign bus.out_x_wdata   = head.x_wdata;
    assign bus.out_x_wb      = head.x_wb;
    assign bus.count         = count;
    assign bus.halted        = (state == HALTED);
    assign bus.err_order     = err_order_q;
    assign bus.err_exp       = err_exp_q;
    assign bus.err_got       = err_got_q;
    assign bus.err_post_halt = err_post_halt_q;
endmodule
